// File: rtl/srt_div_pkg.sv
// Shared definitions for the radix-4 SRT divider post stage.
// Holds state encoding, special-operand codes and IEEE-754 constants.
package srt_div_pkg;

    localparam int NDIGITS = 14;
    localparam int QW      = 2 * NDIGITS;
    localparam int CNTW    = $clog2(NDIGITS + 1);

    localparam int BIAS = 127;
    localparam int MANW = 23;
    localparam int EXPW = 8;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_CORRECT,
        ST_ROUND,
        ST_DONE
    } post_state_e;

    typedef enum logic [1:0] {
        SP_NORMAL = 2'b00,
        SP_ZERO   = 2'b01,
        SP_INF    = 2'b10,
        SP_NAN    = 2'b11
    } special_e;

endpackage

// File: rtl/srt_otf_convert.sv
// On-the-fly conversion of signed radix-4 digits into Q and QM = Q - ulp.
// Ports: clear/shift/qdigit in, pad left-aligns a short digit string; q, qm, count out.
module srt_otf_convert
    import srt_div_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            clear,
    input  logic            shift,
    input  logic [2:0]      qdigit,
    input  logic            pad,
    output logic [QW-1:0]   q,
    output logic [QW-1:0]   qm,
    output logic [CNTW-1:0] count
);

    logic [1:0]    qd_lo;
    logic [1:0]    qm_lo;
    logic          dig_pos;
    logic [CNTW:0] shamt;

    // Low two bits of the digit equal 4+q for negative digits, and the
    // QM digit is always that value minus one (mod 4).
    assign qd_lo   = qdigit[1:0];
    assign qm_lo   = qdigit[1:0] - 2'd1;
    assign dig_pos = ~qdigit[2] & (|qdigit[1:0]);
    assign shamt   = {CNTW'(NDIGITS) - count, 1'b0};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q     <= '0;
            qm    <= '0;
            count <= '0;
        end else if (clear) begin
            q     <= '0;
            qm    <= '0;
            count <= '0;
        end else if (pad) begin
            q  <= q << shamt;
            qm <= qm << shamt;
        end else if (shift && (count < CNTW'(NDIGITS))) begin
            q     <= qdigit[2] ? {qm[QW-3:0], qd_lo} : {q[QW-3:0], qd_lo};
            qm    <= dig_pos   ? {q[QW-3:0], qm_lo} : {qm[QW-3:0], qm_lo};
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/srt_quotient_post.sv
// SRT divider post stage: digit conversion, remainder correction, RNE rounding, packing.
// Ports: start/sign_in/exp_in/special_in, shiftq/qdigit, doneq/rem_*; result/flags/result_valid/busy.
module srt_quotient_post
    import srt_div_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        sign_in,
    input  logic [9:0]  exp_in,
    input  logic [1:0]  special_in,
    input  logic        shiftq,
    input  logic [2:0]  qdigit,
    input  logic        doneq,
    input  logic        rem_neg,
    input  logic        rem_zero,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic [2:0]  flags
);

    post_state_e        state, state_nxt;
    logic [QW-1:0]      q, qm, qf;
    logic [CNTW-1:0]    count;
    logic               take_done;
    logic               sign_r, rneg_r, rzero_r, sticky;
    logic signed [9:0]  exp_r;
    special_e           special_r;

    logic               norm, g, s, inc;
    logic [QW-1:0]      qn;
    logic [MANW:0]      sig;
    logic [MANW+1:0]    sum;
    logic [MANW-1:0]    mant;
    logic signed [9:0]  exp_n, exp_f;
    logic [31:0]        res_c;
    logic [2:0]         flg_c;

    assign take_done = (state == ST_ACCUM) && doneq && !start;
    assign busy      = (state != ST_IDLE);

    srt_otf_convert u_otf (
        .clk    (clk),
        .resetn (resetn),
        .clear  (start),
        .shift  ((state == ST_ACCUM) && shiftq),
        .qdigit (qdigit),
        .pad    (take_done),
        .q      (q),
        .qm     (qm),
        .count  (count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_ACCUM;
        end else begin
            case (state)
                ST_IDLE:    state_nxt = ST_IDLE;
                ST_ACCUM:   if (doneq) state_nxt = ST_CORRECT;
                ST_CORRECT: state_nxt = ST_ROUND;
                ST_ROUND:   state_nxt = ST_DONE;
                ST_DONE:    state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // Quotient lies in (0.5,2): at most one left shift normalises it.
    always_comb begin
        norm  = ~qf[QW-2];
        qn    = norm ? {qf[QW-2:0], 1'b0} : qf;
        exp_n = norm ? exp_r - 10'sd1 : exp_r;
        sig   = qn[QW-2 -: MANW+1];
        g     = qn[QW-2-(MANW+1)];
        s     = (|qn[QW-3-(MANW+1):0]) | sticky;
        inc   = g & (sig[0] | s);
        sum   = {1'b0, sig} + {{(MANW+1){1'b0}}, inc};
        exp_f = sum[MANW+1] ? exp_n + 10'sd1 : exp_n;
        mant  = sum[MANW+1] ? '0 : sum[MANW-1:0];
        res_c = {sign_r, exp_f[EXPW-1:0], mant};
        flg_c = {g | s, 2'b00};
        if (exp_f >= 10'sd255) begin
            res_c = {sign_r, PINF[30:0]};
            flg_c = 3'b101;
        end else if (exp_f <= 10'sd0) begin
            res_c = {sign_r, 31'b0};
            flg_c = {g | s, 2'b10};
        end
        case (special_r)
            SP_NAN: begin
                res_c = QNAN;
                flg_c = 3'b000;
            end
            SP_INF: begin
                res_c = {sign_r, PINF[30:0]};
                flg_c = 3'b000;
            end
            SP_ZERO: begin
                res_c = {sign_r, 31'b0};
                flg_c = 3'b000;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sign_r       <= 1'b0;
            exp_r        <= '0;
            special_r    <= SP_NORMAL;
            rneg_r       <= 1'b0;
            rzero_r      <= 1'b0;
            qf           <= '0;
            sticky       <= 1'b0;
            result       <= '0;
            flags        <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (start) begin
                sign_r    <= sign_in;
                exp_r     <= exp_in;
                special_r <= special_e'(special_in);
            end
            if (take_done) begin
                rneg_r  <= rem_neg;
                rzero_r <= rem_zero;
            end
            if (state == ST_CORRECT) begin
                qf     <= rneg_r ? qm : q;
                sticky <= ~rzero_r;
            end
            if ((state == ST_ROUND) && !start) begin
                result       <= res_c;
                flags        <= flg_c;
                result_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_srt_quotient_post.sv
// Directed bench for srt_quotient_post with hand-computed IEEE-754 results.
// Checks latency, pulse width, rounding, flags, specials, abort and reset.
module tb_srt_quotient_post;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start, sign_in, shiftq, doneq, rem_neg, rem_zero;
    logic [9:0]  exp_in;
    logic [1:0]  special_in;
    logic [2:0]  qdigit;
    logic [31:0] result;
    logic        result_valid, busy;
    logic [2:0]  flags;

    int total = 0;
    int bad   = 0;
    logic [2:0] dq[$];

    srt_quotient_post dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .sign_in      (sign_in),
        .exp_in       (exp_in),
        .special_in   (special_in),
        .shiftq       (shiftq),
        .qdigit       (qdigit),
        .doneq        (doneq),
        .rem_neg      (rem_neg),
        .rem_zero     (rem_zero),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .flags        (flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic fill_zeros(input int upto);
        while (dq.size() < upto) dq.push_back(3'b000);
    endtask

    task automatic begin_div(input logic sg, input logic [9:0] ex,
                             input logic [1:0] sp);
        start = 1'b1; sign_in = sg; exp_in = ex; special_in = sp;
        tick();
        start = 1'b0;
        foreach (dq[i]) begin
            shiftq = 1'b1; qdigit = dq[i];
            tick();
        end
        shiftq = 1'b0; qdigit = 3'b000;
    endtask

    task automatic run_div(input string tag, input logic sg,
                           input logic [9:0] ex, input logic [1:0] sp,
                           input logic rn, input logic rz,
                           input logic [31:0] er, input logic [2:0] ef);
        begin_div(sg, ex, sp);
        doneq = 1'b1; rem_neg = rn; rem_zero = rz;
        tick();
        doneq = 1'b0; rem_neg = 1'b0; rem_zero = 1'b0;
        chk({tag, "_rv_k"}, 32'(result_valid), 32'd0);
        tick();
        chk({tag, "_rv_k1"}, 32'(result_valid), 32'd0);
        tick();
        chk({tag, "_rv_k2"}, 32'(result_valid), 32'd1);
        chk({tag, "_res"}, result, er);
        chk({tag, "_flags"}, 32'(flags), 32'(ef));
        chk({tag, "_busy_k2"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_rv_k3"}, 32'(result_valid), 32'd0);
        chk({tag, "_idle_k3"}, 32'(busy), 32'd0);
        chk({tag, "_hold"}, result, er);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; sign_in = 1'b0; exp_in = '0;
        special_in = 2'b00; shiftq = 1'b0; qdigit = '0; doneq = 1'b0;
        rem_neg = 1'b0; rem_zero = 1'b0;
        tick(); tick();
        chk("rst_result", result, 32'h0);
        chk("rst_rv", 32'(result_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        resetn = 1'b1;
        tick();

        // 1.5, exact
        dq = '{3'b010, 3'b110}; fill_zeros(14);
        run_div("t1", 1'b0, 10'd127, 2'b00, 1'b0, 1'b1, 32'h3FC0_0000, 3'b000);

        // 0.75 - ulp via QM, normalise, round up
        dq = '{3'b001, 3'b111}; fill_zeros(14);
        run_div("t2", 1'b0, 10'd127, 2'b00, 1'b1, 1'b0, 32'h3F40_0000, 3'b100);

        // 2 - 2^-24: tie to even with significand carry
        dq = '{3'b010}; fill_zeros(12);
        dq.push_back(3'b111); dq.push_back(3'b000);
        run_div("t3", 1'b0, 10'd127, 2'b00, 1'b0, 1'b1, 32'h4000_0000, 3'b100);

        // overflow
        dq = '{3'b010, 3'b110}; fill_zeros(14);
        run_div("t4ov", 1'b0, 10'd255, 2'b00, 1'b0, 1'b1, 32'h7F80_0000, 3'b101);

        // underflow to signed zero
        dq = '{3'b001}; fill_zeros(14);
        run_div("t4uf", 1'b1, 10'd0, 2'b00, 1'b0, 1'b1, 32'h8000_0000, 3'b010);

        // NaN with random digits
        dq.delete();
        for (int i = 0; i < 14; i++)
            dq.push_back(3'($urandom_range(0, 4)) - 3'd2);
        run_div("t5nan", 1'b0, 10'd127, 2'b11, 1'b0, 1'b0, 32'h7FC0_0000, 3'b000);

        // signed infinity special
        dq = '{3'b001, 3'b010}; fill_zeros(14);
        run_div("t5inf", 1'b1, 10'd127, 2'b10, 1'b0, 1'b1, 32'hFF80_0000, 3'b000);

        // short digit string padded: +1,+2 -> 1.5
        dq = '{3'b001, 3'b010};
        run_div("pad", 1'b0, 10'd127, 2'b00, 1'b0, 1'b1, 32'h3FC0_0000, 3'b000);

        // extra digits beyond NDIGITS are ignored
        dq = '{3'b010, 3'b110}; fill_zeros(14);
        dq.push_back(3'b010); dq.push_back(3'b001);
        run_div("extra", 1'b0, 10'd127, 2'b00, 1'b0, 1'b1, 32'h3FC0_0000, 3'b000);

        // abort after 5 digits, then a clean division
        dq = '{3'b001, 3'b010, 3'b111, 3'b001, 3'b110};
        begin_div(1'b1, 10'd100, 2'b00);
        chk("abort_busy", 32'(busy), 32'd1);
        dq = '{3'b010, 3'b110}; fill_zeros(14);
        run_div("t6abort", 1'b0, 10'd127, 2'b00, 1'b0, 1'b1, 32'h3FC0_0000, 3'b000);

        // doneq held four cycles: exactly one pulse
        dq = '{3'b001, 3'b111}; fill_zeros(14);
        begin_div(1'b0, 10'd127, 2'b00);
        doneq = 1'b1; rem_neg = 1'b1; rem_zero = 1'b0;
        tick();
        chk("hold_rv_k", 32'(result_valid), 32'd0);
        tick();
        chk("hold_rv_k1", 32'(result_valid), 32'd0);
        tick();
        chk("hold_rv_k2", 32'(result_valid), 32'd1);
        chk("hold_res", result, 32'h3F40_0000);
        tick();
        chk("hold_rv_k3", 32'(result_valid), 32'd0);
        doneq = 1'b0; rem_neg = 1'b0;
        tick();
        chk("hold_rv_k4", 32'(result_valid), 32'd0);
        tick();
        chk("hold_rv_k5", 32'(result_valid), 32'd0);
        chk("hold_busy", 32'(busy), 32'd0);

        // reset asserted while in ROUND
        dq = '{3'b010, 3'b110}; fill_zeros(14);
        begin_div(1'b0, 10'd127, 2'b00);
        doneq = 1'b1; rem_zero = 1'b1;
        tick();
        doneq = 1'b0; rem_zero = 1'b0;
        tick();
        chk("rr_busy_pre", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        chk("rr_result", result, 32'h0);
        chk("rr_flags", 32'(flags), 32'd0);
        chk("rr_busy", 32'(busy), 32'd0);
        chk("rr_rv", 32'(result_valid), 32'd0);
        tick();
        tick();
        chk("rr_rv_late", 32'(result_valid), 32'd0);
        resetn = 1'b1;
        tick();
        chk("rr_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
